// File: rtl/pixel_pkg.sv
// pixel_pkg: shared sequencer state encoding and pixel array default sizes.
package pixel_pkg;
  localparam int PIXEL_COUNT = 4;
  localparam int COUNTER_WIDTH = 8;
  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CLR,
    CONVERT,
    RD_SETUP,
    RD_CAPTURE,
    RD_WAIT
  } seq_state_t;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that parks at zero and flags done there.
module phase_timer #(
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_value,
  input  logic                   en,
  output logic                   done
);
  logic [TIMER_WIDTH-1:0] count;
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (load) count <= load_value;
    else if (en && count != '0) count <= count - 1'b1;
  end
  assign done = count == '0;
endmodule

// File: rtl/pixel_array_sequencer.sv
// pixel_array_sequencer: erase/expose/convert/read-out frame controller with valid/ready pixel stream.
module pixel_array_sequencer #(
  parameter int PIXEL_COUNT    = pixel_pkg::PIXEL_COUNT,
  parameter int COUNTER_WIDTH  = pixel_pkg::COUNTER_WIDTH,
  parameter int ERASE_CYCLES   = 5,
  parameter int EXPOSE_CYCLES  = 255,
  parameter int CONVERT_CYCLES = 255,
  parameter int TIMER_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           continuous,
  output logic                           busy,
  output logic                           array_reset,
  output logic                           erase,
  output logic                           expose,
  output logic                           convert,
  output logic                           read,
  output logic [$clog2(PIXEL_COUNT)-1:0] pixel_select,
  input  logic [COUNTER_WIDTH-1:0]       data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COUNTER_WIDTH-1:0]       out_data,
  output logic [$clog2(PIXEL_COUNT)-1:0] out_index,
  output logic                           frame_done
);
  import pixel_pkg::*;
  localparam int IW = $clog2(PIXEL_COUNT);
  seq_state_t state, state_n;
  logic [IW-1:0] idx_n;
  logic [TIMER_WIDTH-1:0] ld_val;
  logic ld, t_done, accept, last;
  phase_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
    .clk       (clk),
    .rst       (reset),
    .load      (ld),
    .load_value(ld_val),
    .en        (1'b1),
    .done      (t_done)
  );
  assign accept = out_valid && out_ready;
  assign last   = pixel_select == IW'(PIXEL_COUNT - 1);
  // The timer is loaded on the transition into each timed phase so the phase lasts exactly *_CYCLES clocks.
  always_comb begin
    state_n = state;
    ld      = 1'b0;
    ld_val  = '0;
    case (state)
      IDLE: begin
        state_n = start ? ERASE : IDLE;
        ld      = start;
        ld_val  = TIMER_WIDTH'(ERASE_CYCLES - 1);
      end
      ERASE: begin
        state_n = t_done ? EXPOSE : ERASE;
        ld      = t_done;
        ld_val  = TIMER_WIDTH'(EXPOSE_CYCLES - 1);
      end
      EXPOSE: state_n = t_done ? CLR : EXPOSE;
      CLR: begin
        state_n = CONVERT;
        ld      = 1'b1;
        ld_val  = TIMER_WIDTH'(CONVERT_CYCLES - 1);
      end
      CONVERT:    state_n = t_done ? RD_SETUP : CONVERT;
      RD_SETUP:   state_n = RD_CAPTURE;
      RD_CAPTURE: state_n = RD_WAIT;
      RD_WAIT: begin
        state_n = !accept ? RD_WAIT : !last ? RD_SETUP : continuous ? ERASE : IDLE;
        ld      = accept && last && continuous;
        ld_val  = TIMER_WIDTH'(ERASE_CYCLES - 1);
      end
      default: state_n = IDLE;
    endcase
  end
  assign idx_n = (state == CONVERT && state_n == RD_SETUP) ? '0 :
                 (state == RD_WAIT && accept && !last) ? pixel_select + 1'b1 : pixel_select;
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      array_reset  <= 1'b0;
      erase        <= 1'b0;
      expose       <= 1'b0;
      convert      <= 1'b0;
      read         <= 1'b0;
      pixel_select <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      busy         <= state_n != IDLE;
      array_reset  <= state_n == CLR;
      erase        <= state_n == ERASE;
      expose       <= state_n == EXPOSE;
      convert      <= state_n == CONVERT;
      read         <= state_n == RD_SETUP || state_n == RD_CAPTURE;
      pixel_select <= idx_n;
      frame_done   <= state == RD_WAIT && accept && last;
      if (state == RD_CAPTURE) begin
        out_valid <= 1'b1;
        out_data  <= data_in;
        out_index <= pixel_select;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_array_sequencer.sv
// tb_pixel_array_sequencer: directed tables plus randomized runs against a frame-timeline reference model.
module tb_pixel_array_sequencer;
  localparam int E1 = 5, X1 = 255, C1 = 255, N1 = 4;
  localparam int E2 = 1, X2 = 1, C2 = 1, N2 = 2;
  localparam logic [7:0] B = 8'h80, AR = 8'h40, ER = 8'h20, EX = 8'h10, CV = 8'h08, RD = 8'h04, OV = 8'h02, FD = 8'h01;

  logic clk = 1'b0;
  logic reset, start, continuous, out_ready;
  logic [7:0] tbl [4];
  logic busy1, ar1, er1, ex1, cv1, rd1, ov1, fd1;
  logic [1:0] ps1, ix1;
  logic [7:0] d1, din1;
  logic busy2, ar2, er2, ex2, cv2, rd2, ov2, fd2;
  logic ps2, ix2;
  logic [7:0] d2, din2;
  int checks = 0, passes = 0;

  always #5 clk = ~clk;
  assign din1 = tbl[ps1];
  assign din2 = tbl[{1'b0, ps2}];

  pixel_array_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .busy(busy1), .array_reset(ar1), .erase(er1), .expose(ex1), .convert(cv1), .read(rd1),
    .pixel_select(ps1), .data_in(din1), .out_valid(ov1), .out_ready(out_ready),
    .out_data(d1), .out_index(ix1), .frame_done(fd1)
  );

  pixel_array_sequencer #(
    .PIXEL_COUNT(N2), .ERASE_CYCLES(E2), .EXPOSE_CYCLES(X2), .CONVERT_CYCLES(C2)
  ) dut_min (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .busy(busy2), .array_reset(ar2), .erase(er2), .expose(ex2), .convert(cv2), .read(rd2),
    .pixel_select(ps2), .data_in(din2), .out_valid(ov2), .out_ready(out_ready),
    .out_data(d2), .out_index(ix2), .frame_done(fd2)
  );

  function automatic logic [31:0] pk(logic [7:0] f, logic [3:0] ps, logic [3:0] ix, logic [7:0] d);
    return {f, ps, ix, 8'h00, d};
  endfunction

  logic [31:0] vec1, vec2;
  assign vec1 = pk({busy1, ar1, er1, ex1, cv1, rd1, ov1, fd1}, {2'b0, ps1}, {2'b0, ix1}, d1);
  assign vec2 = pk({busy2, ar2, er2, ex2, cv2, rd2, ov2, fd2}, {3'b0, ps2}, {3'b0, ix2}, d2);

  // Frame timeline model: t counts clocks since ERASE began; read-out walks pixel p through setup/capture/wait.
  typedef struct {
    bit on;
    int t, p, s, idx;
    bit v, done;
    logic [7:0] d;
  } model_t;
  model_t m1, m2;

  function automatic model_t step(model_t m, int e, int x, int c, int n, bit r, bit st, bit ct, bit rdy);
    int rl = e + x + 1 + c;
    if (r) return '{default: 0};
    m.done = 0;
    if (!m.on) begin
      if (st) begin m.on = 1; m.t = 0; end
    end else if (m.t < rl) begin
      m.t = m.t + 1;
      if (m.t == rl) begin m.p = 0; m.s = 0; end
    end else if (m.s == 0) begin
      m.s = 1;
    end else if (m.s == 1) begin
      m.v = 1; m.d = tbl[m.p]; m.idx = m.p; m.s = 2;
    end else if (m.v && rdy) begin
      m.v = 0;
      if (m.p == n - 1) begin
        m.done = 1;
        if (ct) m.t = 0; else m.on = 0;
      end else begin
        m.p = m.p + 1; m.s = 0;
      end
    end
    return m;
  endfunction

  function automatic logic [31:0] exp_vec(model_t m, int e, int x, int c);
    int rl = e + x + 1 + c;
    logic [7:0] f;
    f = {m.on, m.on && m.t == e + x, m.on && m.t < e, m.on && m.t >= e && m.t < e + x,
         m.on && m.t > e + x && m.t < rl, m.on && m.t >= rl && m.s < 2, m.v, m.done};
    return pk(f, 4'(m.p), 4'(m.idx), m.d);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic tick(input bit r, input bit st, input bit ct, input bit rdy);
    reset = r; start = st; continuous = ct; out_ready = rdy;
    @(posedge clk);
    m1 = step(m1, E1, X1, C1, N1, r, st, ct, rdy);
    m2 = step(m2, E2, X2, C2, N2, r, st, ct, rdy);
    #1;
    chk("model_default", vec1, exp_vec(m1, E1, X1, C1));
    chk("model_minimal", vec2, exp_vec(m2, E2, X2, C2));
  endtask

  task automatic run_until_done(input bit ct, output int n);
    n = 0;
    while (!fd1 && n < 3000) begin
      tick(0, 0, ct, 1);
      n++;
    end
    chk("frame_done_timeout", 32'(fd1), 32'd1);
  endtask

  typedef struct {
    int dut;
    int cyc;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[$];

  initial begin
    int n;
    m1 = '{default: 0};
    m2 = '{default: 0};
    for (int i = 0; i < 4; i++) tbl[i] = 8'hA0 + 8'(i);
    tv.push_back('{1, 0,   pk(B | ER, 0, 0, 8'h00)});
    tv.push_back('{1, 4,   pk(B | ER, 0, 0, 8'h00)});
    tv.push_back('{1, 5,   pk(B | EX, 0, 0, 8'h00)});
    tv.push_back('{1, 259, pk(B | EX, 0, 0, 8'h00)});
    tv.push_back('{1, 260, pk(B | AR, 0, 0, 8'h00)});
    tv.push_back('{1, 261, pk(B | CV, 0, 0, 8'h00)});
    tv.push_back('{1, 515, pk(B | CV, 0, 0, 8'h00)});
    tv.push_back('{1, 516, pk(B | RD, 0, 0, 8'h00)});
    tv.push_back('{1, 517, pk(B | RD, 0, 0, 8'h00)});
    tv.push_back('{1, 518, pk(B | OV, 0, 0, 8'hA0)});
    tv.push_back('{1, 519, pk(B | RD, 1, 0, 8'hA0)});
    tv.push_back('{1, 521, pk(B | OV, 1, 1, 8'hA1)});
    tv.push_back('{1, 524, pk(B | OV, 2, 2, 8'hA2)});
    tv.push_back('{1, 527, pk(B | OV, 3, 3, 8'hA3)});
    tv.push_back('{1, 528, pk(FD, 3, 3, 8'hA3)});
    tv.push_back('{1, 529, pk(8'h00, 3, 3, 8'hA3)});
    tv.push_back('{2, 0,  pk(B | ER, 0, 0, 8'h00)});
    tv.push_back('{2, 1,  pk(B | EX, 0, 0, 8'h00)});
    tv.push_back('{2, 2,  pk(B | AR, 0, 0, 8'h00)});
    tv.push_back('{2, 3,  pk(B | CV, 0, 0, 8'h00)});
    tv.push_back('{2, 4,  pk(B | RD, 0, 0, 8'h00)});
    tv.push_back('{2, 5,  pk(B | RD, 0, 0, 8'h00)});
    tv.push_back('{2, 6,  pk(B | OV, 0, 0, 8'hA0)});
    tv.push_back('{2, 7,  pk(B | RD, 1, 0, 8'hA0)});
    tv.push_back('{2, 8,  pk(B | RD, 1, 0, 8'hA0)});
    tv.push_back('{2, 9,  pk(B | OV, 1, 1, 8'hA1)});
    tv.push_back('{2, 10, pk(FD, 1, 1, 8'hA1)});
    tv.push_back('{2, 11, pk(8'h00, 1, 1, 8'hA1)});

    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("reset_default", vec1, 32'h0);
    chk("reset_minimal", vec2, 32'h0);

    // Full frame with ready held high; the start at cycle 100 must be ignored.
    for (int c = 0; c < 530; c++) begin
      tick(0, c == 0 || c == 100, 0, 1);
      foreach (tv[i]) if (tv[i].cyc == c) chk($sformatf("table_dut%0d_c%0d", tv[i].dut, c), tv[i].dut == 1 ? vec1 : vec2, tv[i].exp);
    end

    // Backpressure on pixel 2.
    tick(0, 1, 0, 1);
    n = 0;
    while (!(ov1 && ix1 == 2'd2) && n < 1000) begin tick(0, 0, 0, 1); n++; end
    chk("bp_reach_timeout", 32'(ov1 && ix1 == 2'd2), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0);
      chk("bp_hold", {ov1, rd1, ps1, ix1, d1}, {1'b1, 1'b0, 2'd2, 2'd2, 8'hA2});
    end
    run_until_done(0, n);

    // Continuous restart, then a stop with in-frame start pulses.
    tick(0, 0, 0, 1);
    tick(0, 1, 1, 1);
    run_until_done(1, n);
    chk("cont_erase_restart", {busy1, er1}, 2'b11);
    for (int i = 0; i < 50; i++) tick(0, i % 7 == 0, 0, 1);
    run_until_done(0, n);
    chk("cont_second_len", 32'(n), 32'd478);
    tick(0, 0, 0, 1);
    chk("cont_idle_after", {busy1, er1}, 2'b00);

    // Reset during CONVERT, then a clean full frame.
    tick(0, 1, 0, 1);
    for (int i = 0; i < 300; i++) tick(0, 0, 0, 1);
    chk("mid_convert", 32'(cv1), 32'd1);
    tick(1, 0, 0, 1);
    chk("reset_mid_convert", vec1, 32'h0);
    tick(0, 1, 0, 1);
    run_until_done(0, n);
    chk("frame_len_after_reset", 32'(n), 32'd528);

    // Reset while a beat is pending.
    tick(0, 1, 0, 0);
    n = 0;
    while (!ov1 && n < 1000) begin tick(0, 0, 0, 0); n++; end
    chk("wait_valid_timeout", 32'(ov1), 32'd1);
    tick(1, 0, 0, 0);
    chk("reset_mid_wait", vec1, 32'h0);
    chk("reset_mid_wait_min", vec2, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 15000; i++) begin
      if (i % 64 == 0) for (int k = 0; k < 4; k++) tbl[k] = 8'($urandom);
      tick($urandom_range(0, 399) == 0, $urandom_range(0, 99) < 3, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
